rotating_square_disp: RTL and testbench

//  Parametrised rotating-square animation for a multiplexed N-digit 7-segment display.
//  - One square walks a closed loop: along the upper half of every digit, then back

---
 rtl/rsq_pkg.sv | 18 +
 rtl/seg_scan_mux.sv | 44 ++++
 rtl/rotating_square_disp.sv | 104 ++++++++++
 tb/tb_rotating_square_disp.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/rsq_pkg.sv
// Shared constants and position helpers for the rotating-square display.
// Segment patterns are {dp,g,f,e,d,c,b,a}, active-low.
package rsq_pkg;

  localparam logic [7:0] SEG_UPPER = 8'h9C;  // a,b,f,g lit
  localparam logic [7:0] SEG_LOWER = 8'hA3;  // c,d,e,g lit
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Upper half runs left to right, lower half returns right to left.
  function automatic int pos2digit(input int p, input int n);
    return (p < n) ? (n - 1 - p) : (p - n);
  endfunction

  function automatic logic pos_is_upper(input int p, input int n);
    return (p < n);
  endfunction

endpackage

// File: rtl/seg_scan_mux.sv
// Display scan: refresh divider, scan index and the registered active-low
// digit enables (one-hot-zero, bit0 = rightmost digit).
module seg_scan_mux #(
  parameter int NUM_DIGITS  = 8,
  parameter int REFRESH_DIV = 50_000,
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [IW-1:0]         scan_idx,
  output logic [NUM_DIGITS-1:0] digit_n
);

  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV + 1) : 1;

  logic [RW-1:0] ref_cnt;
  logic          adv;

  assign adv = (ref_cnt >= RW'(REFRESH_DIV - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ref_cnt  <= '0;
      scan_idx <= '0;
    end else if (adv) begin
      ref_cnt  <= '0;
      scan_idx <= (scan_idx == IW'(NUM_DIGITS - 1)) ? '0 : scan_idx + 1'b1;
    end else begin
      ref_cnt  <= ref_cnt + 1'b1;
    end
  end

  // Enables lag the index by one clk, matching the registered segment pattern.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      digit_n <= '1;
    end else begin
      for (int j = 0; j < NUM_DIGITS; j++) begin
        digit_n[j] <= (scan_idx != IW'(j));
      end
    end
  end

endmodule

// File: rtl/rotating_square_disp.sv
// Rotating-square animation on a multiplexed N-digit 7-segment display.
// Define RSQ_TRAIL_EN to also draw a trailing square at the previous position.
module rotating_square_disp
  import rsq_pkg::*;
#(
  parameter int NUM_DIGITS  = 8,
  parameter int STEP_DIV    = 25_000_000,
  parameter int REFRESH_DIV = 50_000,
  localparam int PW = $clog2(2 * NUM_DIGITS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  cw,
  input  logic [1:0]            speed_sel,
  output logic [7:0]            seg,
  output logic [NUM_DIGITS-1:0] digit,
  output logic [PW-1:0]         pos,
  output logic                  step
);

  localparam int L  = 2 * NUM_DIGITS;
  localparam int DW = $clog2(STEP_DIV * 8 + 1);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [DW-1:0] div_cnt;
  logic [DW-1:0] period;
  logic          step_hit;
  logic [PW-1:0] pos_next;
  logic [IW-1:0] scan_idx;
  logic [7:0]    seg_next;

  seg_scan_mux #(
    .NUM_DIGITS (NUM_DIGITS),
    .REFRESH_DIV(REFRESH_DIV)
  ) u_scan (
    .clk     (clk),
    .rst_n   (rst_n),
    .scan_idx(scan_idx),
    .digit_n (digit)
  );

  // '>=' rather than '==' so a speed drop below the running count steps at once.
  assign period   = DW'(STEP_DIV) << speed_sel;
  assign step_hit = en && (div_cnt >= period - DW'(1));

  always_comb begin
    pos_next = pos;
    if (cw) pos_next = (pos == PW'(L - 1)) ? '0 : pos + 1'b1;
    else    pos_next = (pos == '0) ? PW'(L - 1) : pos - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt <= '0;
      pos     <= '0;
      step    <= 1'b0;
    end else begin
      step <= step_hit;
      if (step_hit) begin
        div_cnt <= '0;
        pos     <= pos_next;
      end else if (en) begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

`ifdef RSQ_TRAIL_EN
  logic [PW-1:0] trail_pos;
  logic          trail_vld;

  // The position being left behind is exactly the trail position.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      trail_pos <= '0;
      trail_vld <= 1'b0;
    end else if (step_hit) begin
      trail_pos <= pos;
      trail_vld <= 1'b1;
    end
  end
`endif

  always_comb begin
    seg_next = SEG_BLANK;
    if (pos2digit(int'(pos), NUM_DIGITS) == int'(scan_idx)) begin
      seg_next = pos_is_upper(int'(pos), NUM_DIGITS) ? SEG_UPPER : SEG_LOWER;
    end
`ifdef RSQ_TRAIL_EN
    // Active-low AND merges both halves into a full square on a shared digit.
    if (trail_vld && (pos2digit(int'(trail_pos), NUM_DIGITS) == int'(scan_idx))) begin
      seg_next = seg_next &
                 (pos_is_upper(int'(trail_pos), NUM_DIGITS) ? SEG_UPPER : SEG_LOWER);
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) seg <= SEG_BLANK;
    else        seg <= seg_next;
  end

endmodule

// File: tb/tb_rotating_square_disp.sv
// Bench for rotating_square_disp: N=4, STEP_DIV=4, REFRESH_DIV=2.
// Steps are scored from an expected queue of {gap, pos}; gap 0 means unchecked.
module tb_rotating_square_disp;

  localparam int N  = 4;
  localparam int PW = 3;
  localparam int W  = 16 + PW;

`ifdef RSQ_TRAIL_EN
  localparam logic [7:0] EXP_D3_P0 = 8'h80;
  localparam logic [7:0] EXP_D3_P7 = 8'h80;
`else
  localparam logic [7:0] EXP_D3_P0 = 8'h9C;
  localparam logic [7:0] EXP_D3_P7 = 8'hA3;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic          cw;
  logic [1:0]    speed_sel;
  logic [7:0]    seg;
  logic [N-1:0]  digit;
  logic [PW-1:0] pos;
  logic          step;

  logic [W-1:0] exp_q[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_step_cyc = 0;
  int step_cnt = 0;

  rotating_square_disp #(
    .NUM_DIGITS (N),
    .STEP_DIV   (4),
    .REFRESH_DIV(2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .cw       (cw),
    .speed_sel(speed_sel),
    .seg      (seg),
    .digit    (digit),
    .pos      (pos),
    .step     (step)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic push_exp(input int p, input int gap);
    exp_q.push_back({16'(gap), PW'(p)});
  endtask

  // driver tasks
  task automatic wait_step(input string name);
    int n = 0;
    @(negedge clk);
    while (step !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (step !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL %s: no step within 100 cycles, pos=%0d", name, pos);
    end
  endtask

  task automatic wait_digit(input logic [N-1:0] d, input string name);
    int n = 0;
    @(negedge clk);
    while (digit !== d && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (digit !== d) begin
      total++;
      bad++;
      $display("FAIL %s: digit %0h never reached, saw %0h", name, d, digit);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (rst_n === 1'b1 && step === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_step: got step at pos=%0d expected none", pos);
      end else begin
        e = exp_q.pop_front();
        chk("step_pos", 32'(pos), 32'(e[PW-1:0]));
        if (e[W-1:PW] != 16'd0) chk("step_gap", cyc - last_step_cyc, 32'(e[W-1:PW]));
      end
      last_step_cyc = cyc;
      step_cnt++;
    end
  end

  initial begin
    logic [N-1:0] seq_tbl[4];
    logic [N-1:0] prev_d;
    int freeze_start;
    int n;
    seq_tbl[0] = 4'hE; seq_tbl[1] = 4'hD; seq_tbl[2] = 4'hB; seq_tbl[3] = 4'h7;

    rst_n = 1'b0; en = 1'b0; cw = 1'b1; speed_sel = 2'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_seg", 32'(seg), 32'h FF);
    chk("reset_digit", 32'(digit), 32'hF);
    chk("reset_pos", 32'(pos), 0);
    chk("reset_step", 32'(step), 0);

    // full clockwise loop 1..7,0
    push_exp(1, 0);
    for (int p = 2; p <= 8; p++) push_exp(p % 8, 4);
    rst_n = 1'b1; en = 1'b1;
    for (int k = 0; k < 8; k++) wait_step("cw_loop");

    // freeze two counts into the period at pos 0
    @(negedge clk);
    @(negedge clk);
    en = 1'b0;
    freeze_start = cyc;
    prev_d = digit;
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (digit === 4'hE && prev_d !== 4'hE) break;
      prev_d = digit;
    end
    for (int j = 1; j < 8; j++) begin
      @(negedge clk);
      chk("scan_order", 32'(digit), 32'(seq_tbl[j >> 1]));
    end
    wait_digit(4'h7, "p0_d3");
    chk("p0_d3_seg", 32'(seg), 32'(EXP_D3_P0));
    wait_digit(4'hE, "p0_d0");
    chk("p0_d0_seg", 32'(seg), 32'hFF);
    while (cyc - freeze_start < 20) @(negedge clk);
    chk("freeze_pos", 32'(pos), 0);
    chk("freeze_steps", step_cnt, 8);

    // resume counter-clockwise; two counts remain in the period
    push_exp(7, cyc - freeze_start + 4);
    cw = 1'b0; en = 1'b1;
    wait_step("resume");
    en = 1'b0;
    wait_digit(4'h7, "p7_d3");
    chk("p7_d3_seg", 32'(seg), 32'(EXP_D3_P7));
    wait_digit(4'hE, "p7_d0");
    chk("p7_d0_seg", 32'(seg), 32'hFF);

    push_exp(6, 0); push_exp(5, 4); push_exp(4, 4);
    en = 1'b1;
    for (int k = 0; k < 3; k++) wait_step("ccw_run");
    en = 1'b0;
    wait_digit(4'hE, "p4_d0");
    chk("p4_d0_seg", 32'(seg), 32'hA3);
    wait_digit(4'h7, "p4_d3");
    chk("p4_d3_seg", 32'(seg), 32'hFF);

    // slow speed, then drop it with the count at 10
    push_exp(5, 0); push_exp(6, 16);
    en = 1'b1; cw = 1'b1; speed_sel = 2'd2;
    wait_step("slow_a");
    wait_step("slow_b");
    repeat (10) @(negedge clk);
    push_exp(7, 11);
    speed_sel = 2'd0;
    wait_step("speed_drop");

    push_exp(6, 4); push_exp(5, 4);
    cw = 1'b0;
    wait_step("to_p6");
    wait_step("to_p5");
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midreset_pos", 32'(pos), 0);
    chk("midreset_seg", 32'(seg), 32'hFF);
    chk("midreset_digit", 32'(digit), 32'hF);
    chk("midreset_step", 32'(step), 0);
    chk("queue_drained", exp_q.size(), 0);

`ifdef RSQ_TRAIL_EN
    push_exp(1, 0);
    for (int p = 2; p <= 4; p++) push_exp(p, 4);
    rst_n = 1'b1; en = 1'b1; cw = 1'b1;
    for (int k = 0; k < 4; k++) wait_step("trail_run");
    en = 1'b0;
    wait_digit(4'hE, "trail_d0");
    chk("trail_full_square", 32'(seg), 32'h80);
    wait_digit(4'h7, "trail_d3");
    chk("trail_d3_seg", 32'(seg), 32'hFF);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
